// File: rtl/nand_phy_pkg.sv
// Shared types and counter widths for the NAND ready/busy input stage.
package nand_phy_pkg;

  localparam int WB_W   = 8;
  localparam int TO_W   = 24;
  localparam int FILT_W = 4;

  typedef enum logic [1:0] {
    TRK_IDLE,
    TRK_WAIT_BUSY,
    TRK_BUSY
  } trk_state_t;

endpackage

// File: rtl/nand_rb_chan.sv
// One chip's ready/busy channel: sync stage 2, glitch filter and the
// arm -> busy -> ready operation tracker.
module nand_rb_chan #(
  parameter int FILTER_CYCLES  = 4,
  parameter int WB_CYCLES      = 20,
  parameter int TIMEOUT_CYCLES = 10000000
) (
  input  logic clk0,
  input  logic rst0n,
  input  logic rb_s1,
  input  logic arm,
  output logic rb_level,
  output logic busy,
  output logic done,
  output logic timeout
);
  import nand_phy_pkg::*;

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);
  localparam logic [WB_W-1:0]   WB_LOAD   = WB_W'(WB_CYCLES);
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYCLES);

  logic              s2_reg;
  logic              filt_reg, filt_next;
  logic [FILT_W-1:0] filt_cnt_reg, filt_cnt_next;
  trk_state_t        state_reg, state_next;
  logic [WB_W-1:0]   wb_cnt_reg, wb_cnt_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic              done_reg, done_next;
  logic              timeout_reg, timeout_next;

  always_ff @(posedge clk0 or negedge rst0n) begin
    if (!rst0n) begin
      s2_reg       <= 1'b1;
      filt_reg     <= 1'b1;
      filt_cnt_reg <= '0;
      state_reg    <= TRK_IDLE;
      wb_cnt_reg   <= '0;
      to_cnt_reg   <= '0;
      done_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      s2_reg       <= rb_s1;
      filt_reg     <= filt_next;
      filt_cnt_reg <= filt_cnt_next;
      state_reg    <= state_next;
      wb_cnt_reg   <= wb_cnt_next;
      to_cnt_reg   <= to_cnt_next;
      done_reg     <= done_next;
      timeout_reg  <= timeout_next;
    end
  end

  // The level only flips after FILTER_CYCLES consecutive disagreeing samples.
  always_comb begin
    filt_next     = filt_reg;
    filt_cnt_next = '0;
    if (s2_reg != filt_reg) begin
      if (filt_cnt_reg == FILT_LAST) begin
        filt_next = s2_reg;
      end else begin
        filt_cnt_next = filt_cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    wb_cnt_next  = wb_cnt_reg;
    to_cnt_next  = to_cnt_reg;
    done_next    = 1'b0;
    timeout_next = timeout_reg;
    case (state_reg)
      TRK_IDLE: begin
        if (arm) begin
          state_next   = TRK_WAIT_BUSY;
          wb_cnt_next  = WB_LOAD;
          timeout_next = 1'b0;
        end
      end
      TRK_WAIT_BUSY: begin
        if (!filt_reg) begin
          state_next  = TRK_BUSY;
          to_cnt_next = TO_LOAD;
        end else if (wb_cnt_reg <= WB_W'(1)) begin
          // Busy never showed up: treat as a fast operation, no timeout.
          wb_cnt_next = '0;
          done_next   = 1'b1;
          state_next  = TRK_IDLE;
        end else begin
          wb_cnt_next = wb_cnt_reg - 1'b1;
        end
      end
      TRK_BUSY: begin
        if (filt_reg) begin
          done_next  = 1'b1;
          state_next = TRK_IDLE;
        end else if (to_cnt_reg <= TO_W'(1)) begin
          to_cnt_next  = '0;
          timeout_next = 1'b1;
          done_next    = 1'b1;
          state_next   = TRK_IDLE;
        end else begin
          to_cnt_next = to_cnt_reg - 1'b1;
        end
      end
      default: state_next = TRK_IDLE;
    endcase
  end

  assign rb_level = filt_reg;
  assign busy     = (state_reg != TRK_IDLE);
  assign done     = done_reg;
  assign timeout  = timeout_reg;

endmodule

// File: rtl/nand_phy_rb_io.sv
// Ready/busy pin capture for one NAND bus: IOB input flops feeding one
// filter/tracker channel per chip.
module nand_phy_rb_io #(
  parameter int RBS_PER_IO     = 4,
  parameter int FILTER_CYCLES  = 4,
  parameter int WB_CYCLES      = 20,
  parameter int TIMEOUT_CYCLES = 10000000
) (
  input  logic                  clk0,
  input  logic                  rst0n,
  input  logic [RBS_PER_IO-1:0] rb,
  input  logic [RBS_PER_IO-1:0] ctrl_arm,
  output logic [RBS_PER_IO-1:0] ctrl_rb,
  output logic [RBS_PER_IO-1:0] ctrl_busy,
  output logic [RBS_PER_IO-1:0] ctrl_done,
  output logic [RBS_PER_IO-1:0] ctrl_timeout
);
  import nand_phy_pkg::*;

  // First sync stage lives in the pad so the asynchronous pin sees a fixed path.
  (* IOB = "FORCE" *) logic [RBS_PER_IO-1:0] rb_s1_reg;

  always_ff @(posedge clk0 or negedge rst0n) begin
    if (!rst0n) begin
      rb_s1_reg <= '1;
    end else begin
      rb_s1_reg <= rb;
    end
  end

  generate
    for (genvar gi = 0; gi < RBS_PER_IO; gi++) begin : g_chan
      nand_rb_chan #(
        .FILTER_CYCLES  (FILTER_CYCLES),
        .WB_CYCLES      (WB_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_chan (
        .clk0     (clk0),
        .rst0n    (rst0n),
        .rb_s1    (rb_s1_reg[gi]),
        .arm      (ctrl_arm[gi]),
        .rb_level (ctrl_rb[gi]),
        .busy     (ctrl_busy[gi]),
        .done     (ctrl_done[gi]),
        .timeout  (ctrl_timeout[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_nand_phy_rb_io.sv
// Scoreboard bench for nand_phy_rb_io: a pin-history / deadline reference model
// predicts levels and done events; a monitor compares every cycle.
module tb_nand_phy_rb_io;
  localparam int N  = 4;
  localparam int F  = 4;
  localparam int WB = 20;
  localparam int TO = 100;
  localparam int H  = 20;

  logic         clk0 = 1'b0;
  logic         rst0n;
  logic [N-1:0] rb;
  logic [N-1:0] ctrl_arm;
  logic [N-1:0] ctrl_rb;
  logic [N-1:0] ctrl_busy;
  logic [N-1:0] ctrl_done;
  logic [N-1:0] ctrl_timeout;

  always #5 clk0 = ~clk0;

  nand_phy_rb_io #(
    .RBS_PER_IO     (N),
    .FILTER_CYCLES  (F),
    .WB_CYCLES      (WB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk0         (clk0),
    .rst0n        (rst0n),
    .rb           (rb),
    .ctrl_arm     (ctrl_arm),
    .ctrl_rb      (ctrl_rb),
    .ctrl_busy    (ctrl_busy),
    .ctrl_done    (ctrl_done),
    .ctrl_timeout (ctrl_timeout)
  );

  typedef struct {
    int cyc;
    int chip;
    bit to;
  } ev_t;

  int  tests  = 0;
  int  failed = 0;
  int  cyc    = 0;
  ev_t dq[$];

  // Reference model state: recent pin samples, clean level, operation phase
  // (0 idle, 1 waiting for busy, 2 busy) with an absolute deadline cycle.
  bit  hist[N][H];
  bit  m_lvl[N];
  int  m_phase[N];
  int  m_deadline[N];
  bit  m_to[N];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic arm_chip(input int i);
    ctrl_arm[i] = 1'b1;
    @(negedge clk0);
    ctrl_arm[i] = 1'b0;
  endtask

  // Reference model, evaluated on every rising edge.
  initial begin
    bit  fp;
    bit  flip;
    ev_t e;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < H; k++) hist[i][k] = 1'b1;
      m_lvl[i] = 1'b1; m_phase[i] = 0; m_deadline[i] = 0; m_to[i] = 1'b0;
    end
    forever begin
      @(posedge clk0);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (!rst0n) begin
          for (int k = 0; k < H; k++) hist[i][k] = 1'b1;
          m_lvl[i] = 1'b1; m_phase[i] = 0; m_to[i] = 1'b0;
        end else begin
          fp = m_lvl[i];
          // Pin seen by the filter lags two cycles; flip when the last F of
          // those samples all disagree with the current level.
          flip = 1'b1;
          for (int k = 1; k <= F; k++) if (hist[i][k] == fp) flip = 1'b0;
          for (int k = H - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
          hist[i][0] = rb[i];
          if (flip) m_lvl[i] = ~fp;
          case (m_phase[i])
            0: if (ctrl_arm[i]) begin
                 m_phase[i] = 1; m_deadline[i] = cyc + WB; m_to[i] = 1'b0;
               end
            1: if (!fp) begin
                 m_phase[i] = 2; m_deadline[i] = cyc + TO;
               end else if (cyc == m_deadline[i]) begin
                 m_phase[i] = 0;
                 e.cyc = cyc; e.chip = i; e.to = 1'b0; dq.push_back(e);
               end
            2: if (fp) begin
                 m_phase[i] = 0;
                 e.cyc = cyc; e.chip = i; e.to = 1'b0; dq.push_back(e);
               end else if (cyc == m_deadline[i]) begin
                 m_phase[i] = 0; m_to[i] = 1'b1;
                 e.cyc = cyc; e.chip = i; e.to = 1'b1; dq.push_back(e);
               end
            default: m_phase[i] = 0;
          endcase
        end
      end
    end
  end

  // Monitor: compares levels every cycle and pops the scoreboard on done pulses.
  initial begin
    bit  exp_done;
    ev_t e;
    forever begin
      @(posedge clk0);
      #2;
      while (dq.size() > 0 && dq[0].cyc < cyc) begin
        e = dq.pop_front();
        tests++; failed++;
        $display("FAIL missed_done chip %0d: expected done at cycle %0d, ctrl_done stayed low", e.chip, e.cyc);
      end
      for (int i = 0; i < N; i++) begin
        check($sformatf("ctrl_rb[%0d]", i), int'(ctrl_rb[i]), int'(m_lvl[i]));
        check($sformatf("ctrl_busy[%0d]", i), int'(ctrl_busy[i]), int'(m_phase[i] != 0));
        check($sformatf("ctrl_timeout[%0d]", i), int'(ctrl_timeout[i]), int'(m_to[i]));
        exp_done = (dq.size() > 0 && dq[0].cyc == cyc && dq[0].chip == i);
        check($sformatf("ctrl_done[%0d]", i), int'(ctrl_done[i]), int'(exp_done));
        if (exp_done) begin
          e = dq.pop_front();
          $display("[TB] cycle %0d chip %0d done timeout=%0b", cyc, i, e.to);
        end
      end
    end
  end

  initial begin
    int hold[N];
    rst0n    = 1'b0;
    rb       = '0;
    ctrl_arm = '0;
    repeat (3) @(negedge clk0);
    #1;
    check("reset_ctrl_rb", int'(ctrl_rb), 15);
    check("reset_ctrl_busy", int'(ctrl_busy), 0);
    check("reset_ctrl_done", int'(ctrl_done), 0);
    check("reset_ctrl_timeout", int'(ctrl_timeout), 0);
    @(negedge clk0);
    rst0n = 1'b1;
    repeat (12) @(negedge clk0);
    rb = '1;
    repeat (12) @(negedge clk0);

    // Glitch rejection on chip 1: 3-cycle pulse filtered, 4-cycle pulse passes.
    rb[1] = 1'b0; repeat (3) @(negedge clk0); rb[1] = 1'b1;
    repeat (12) @(negedge clk0);
    rb[1] = 1'b0; repeat (4) @(negedge clk0); rb[1] = 1'b1;
    repeat (12) @(negedge clk0);

    // Normal operation on chip 2.
    arm_chip(2);
    rb[2] = 1'b0; repeat (60) @(negedge clk0); rb[2] = 1'b1;
    repeat (20) @(negedge clk0);

    // Fast operation on chip 0: busy never seen.
    arm_chip(0);
    repeat (30) @(negedge clk0);

    // Timeout on chip 3, then a fresh arm clears the flag.
    arm_chip(3);
    rb[3] = 1'b0; repeat (120) @(negedge clk0); rb[3] = 1'b1;
    repeat (12) @(negedge clk0);
    arm_chip(3);
    repeat (30) @(negedge clk0);

    // Chip 1: re-arm during BUSY must not reload the timeout.
    arm_chip(1);
    rb[1] = 1'b0; repeat (40) @(negedge clk0);
    arm_chip(1);
    repeat (100) @(negedge clk0);
    rb[1] = 1'b1; repeat (12) @(negedge clk0);

    // Chip 1: reset while BUSY aborts silently.
    arm_chip(1);
    rb[1] = 1'b0; repeat (30) @(negedge clk0);
    rst0n = 1'b0;
    #1;
    check("async_reset_busy", int'(ctrl_busy), 0);
    check("async_reset_rb", int'(ctrl_rb), 15);
    @(negedge clk0);
    rb[1] = 1'b1;
    rst0n = 1'b1;
    repeat (20) @(negedge clk0);

    // Randomized traffic on all chips.
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          rb[i]   = ($urandom_range(0, 2) != 0) ? ~rb[i] : rb[i];
          hold[i] = int'($urandom_range(1, 40));
        end else begin
          hold[i]--;
        end
        ctrl_arm[i] = ($urandom_range(0, 15) == 0);
      end
      @(negedge clk0);
    end
    ctrl_arm = '0;
    rb       = '1;
    repeat (150) @(negedge clk0);

    check("scoreboard_empty", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
